hdmi_video_timing_ctrl: RTL
===========================

Name: hdmi_video_timing_ctrl

Overview:
- Sequences the three TMDS encoder lanes of the HDMI TX path.
- Generates raster timing from H/V counters: active video enable, hsync/vsync, and per-lane 2-bit control codes, including the HDMI video preamble and video guard-band flag.
- Outputs drive each encoder lane's i_de / i_ctrl inputs directly, plus pixel coordinates for the upstream pixel source.
- Sits between the pixel generator and the three tmds_encoder instances, on the pixel clock.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels); must be >= 10 when HDMI_MODE=1
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active low)
- VSYNC_POL, 0, asserted level of vsync
- HDMI_MODE, 1, 1 = emit preamble/guard flag; 0 = DVI (CTL0..3 held 0)

Ports:
- i_pixclk  input  1  pixel clock
- i_reset  input  1  asynchronous reset, active-high
- i_enable  input  1  run timing; low forces idle and counter restart
- o_de  output  1  active video, to all three encoder lanes
- o_ctrl_ch0  output  2  {vsync, hsync} to lane 0 i_ctrl
- o_ctrl_ch1  output  2  {CTL1, CTL0} to lane 1 i_ctrl
- o_ctrl_ch2  output  2  {CTL3, CTL2} to lane 2 i_ctrl
- o_hsync  output  1  hsync at configured polarity
- o_vsync  output  1  vsync at configured polarity
- o_guard  output  1  video guard-band period flag
- o_x  output  12  horizontal position of current output cycle
- o_y  output  12  vertical position of current output cycle
- o_line_start  output  1  one-cycle pulse at x=0
- o_frame_start  output  1  one-cycle pulse at x=0, y=0

Behaviour:
- Reset and idle state:
  - i_reset is asynchronous and active-high.
  - While i_reset is high, or while i_enable is low: counters = 0; o_de=0, o_guard=0, o_line_start=0, o_frame_start=0, o_x=0, o_y=0, o_ctrl_ch1=o_ctrl_ch2=2'b00.
  - o_hsync/o_vsync sit at their inactive level (~HSYNC_POL, ~VSYNC_POL); o_ctrl_ch0 carries those same levels.
- Start-up: first enabled clock edge after idle presents position (0,0) with o_line_start=o_frame_start=1.
- Counters: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL similarly.
  - h_cnt wraps H_TOTAL-1 -> 0; v_cnt increments on h wrap and wraps V_TOTAL-1 -> 0.
- Outputs are registered: the position on o_x/o_y and all flags refer to the same cycle (no skew between them).
- Horizontal FSM: ACTIVE [0,H_ACTIVE) -> FP -> SYNC -> BP -> ACTIVE.
- Vertical FSM: same order; vertical state changes only at x=0.
- o_de = 1 iff x<H_ACTIVE and y<V_ACTIVE.
- hsync asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), on every line.
- vsync asserted for whole lines y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); edges aligned to x=0.
- "Next line active" = (y+1) mod V_TOTAL < V_ACTIVE.
- HDMI_MODE=1, next line active:
  - Preamble: x in [H_TOTAL-10, H_TOTAL-3] -> {CTL3..CTL0}=4'b0001, so o_ctrl_ch1=2'b01 and o_ctrl_ch2=2'b00.
  - Guard: x in {H_TOTAL-2, H_TOTAL-1} -> o_guard=1 and CTL=0.
- All other cycles: CTL=0 and o_guard=0; o_guard and o_de are never both high.
- HDMI_MODE=0: o_ctrl_ch1/ch2=0 and o_guard=0 always.
- Reset or i_enable deassertion mid-line: immediate idle; later restart begins at (0,0). No partial-line resume.
- Widths: counters and o_x/o_y are 12 bits; H_TOTAL and V_TOTAL must be <= 4096.

Test Plan:
- Defaults, reset pulse then i_enable=1 -> first output cycle: o_x=0, o_y=0, o_de=1, o_frame_start=1; o_de high exactly 640 consecutive cycles per active line.
- Line 0 -> o_hsync=0 exactly at x=656..751 (96 cycles); o_ctrl_ch0[0] matches o_hsync; line period 800 cycles.
- Line 10 -> o_ctrl_ch1=2'b01 at x=790..797; o_guard=1 at x=798,799; line 11 x=0 o_de=1. Line 524 shows the same pattern; line 479 shows no preamble and no guard.
- Full frame -> o_vsync=0 on lines 490–491 only; next o_frame_start 420000 cycles after the previous one; o_de never high for y>=480.
- Assert i_reset asynchronously at y=5, x=300 -> outputs idle before the next clock edge; after release, sequence restarts at (0,0) with o_frame_start.
- HDMI_MODE=0, full frame -> o_guard never 1; o_ctrl_ch1 and o_ctrl_ch2 always 2'b00; sync and de timing identical to HDMI_MODE=1.

Source files
------------

// File: rtl/hdmi_video_timing_ctrl.sv
// hdmi_video_timing_ctrl
//   Raster timing generator for the HDMI TX path. It drives the i_de / i_ctrl
//   inputs of the three TMDS encoder lanes directly, and reports the pixel
//   position of each output cycle to the upstream pixel source.
//
//   Ports
//     i_pixclk       pixel clock
//     i_reset        asynchronous reset, active-high
//     i_enable       run timing; low forces idle and a restart at (0,0)
//     o_de           active video, to all three lanes
//     o_ctrl_ch0     {vsync, hsync} for lane 0
//     o_ctrl_ch1     {CTL1, CTL0} for lane 1
//     o_ctrl_ch2     {CTL3, CTL2} for lane 2
//     o_hsync        hsync at HSYNC_POL
//     o_vsync        vsync at VSYNC_POL
//     o_guard        video guard-band flag
//     o_x, o_y       position of the current output cycle
//     o_line_start   one-cycle pulse at x=0
//     o_frame_start  one-cycle pulse at x=0, y=0
//
//   All porch / sync / active parameters must be non-zero, H_BP >= 10 when
//   HDMI_MODE=1, and both totals must fit in 12 bits.
module hdmi_video_timing_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int HDMI_MODE = 1
) (
  input  logic        i_pixclk,
  input  logic        i_reset,
  input  logic        i_enable,
  output logic        o_de,
  output logic [1:0]  o_ctrl_ch0,
  output logic [1:0]  o_ctrl_ch1,
  output logic [1:0]  o_ctrl_ch2,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_guard,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_line_start,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last count of each region; the region FSMs advance when the counter
  // sits on these values.
  localparam logic [11:0] H_ACT_LAST  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] H_FP_LAST   = 12'(H_ACTIVE + H_FP - 1);
  localparam logic [11:0] H_SYNC_LAST = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT_LAST  = 12'(V_ACTIVE - 1);
  localparam logic [11:0] V_FP_LAST   = 12'(V_ACTIVE + V_FP - 1);
  localparam logic [11:0] V_SYNC_LAST = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);

  // Preamble and guard band occupy the last 10 pixels of a line that is
  // followed by an active line.
  localparam logic [11:0] H_PRE_FIRST   = 12'(H_TOTAL - 10);
  localparam logic [11:0] H_PRE_LAST    = 12'(H_TOTAL - 3);
  localparam logic [11:0] H_GUARD_FIRST = 12'(H_TOTAL - 2);

  localparam logic HS_ON   = 1'(HSYNC_POL);
  localparam logic VS_ON   = 1'(VSYNC_POL);
  localparam logic HDMI_EN = (HDMI_MODE != 0);

  typedef enum logic [1:0] {ST_ACTIVE, ST_FP, ST_SYNC, ST_BP} region_e;

  // Counters hold the position that the next enabled edge will present.
  logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  region_e     h_state_q, h_state_d, v_state_q, v_state_d;

  logic        de_q, de_d;
  logic        hsync_on_q, hsync_on_d;
  logic        vsync_on_q, vsync_on_d;
  logic        guard_q, guard_d;
  logic [3:0]  ctl_q, ctl_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  logic h_wrap, v_wrap, next_line_active;

  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);
  // (y+1) mod V_TOTAL < V_ACTIVE
  assign next_line_active = v_wrap || (v_cnt_q < V_ACT_LAST);

  // State register, including the registered outputs.
  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_state_q     <= ST_ACTIVE;
      v_state_q     <= ST_ACTIVE;
      de_q          <= 1'b0;
      hsync_on_q    <= 1'b0;
      vsync_on_q    <= 1'b0;
      guard_q       <= 1'b0;
      ctl_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      de_q          <= de_d;
      hsync_on_q    <= hsync_on_d;
      vsync_on_q    <= vsync_on_d;
      guard_q       <= guard_d;
      ctl_q         <= ctl_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Next-state logic for the counters and the two region FSMs.
  always_comb begin
    h_state_d = h_state_q;
    unique case (h_state_q)
      ST_ACTIVE: if (h_cnt_q == H_ACT_LAST)  h_state_d = ST_FP;
      ST_FP:     if (h_cnt_q == H_FP_LAST)   h_state_d = ST_SYNC;
      ST_SYNC:   if (h_cnt_q == H_SYNC_LAST) h_state_d = ST_BP;
      ST_BP:     if (h_wrap)                 h_state_d = ST_ACTIVE;
    endcase

    // Vertical region only moves on a line wrap, so its edges land on x=0.
    v_state_d = v_state_q;
    if (h_wrap) begin
      unique case (v_state_q)
        ST_ACTIVE: if (v_cnt_q == V_ACT_LAST)  v_state_d = ST_FP;
        ST_FP:     if (v_cnt_q == V_FP_LAST)   v_state_d = ST_SYNC;
        ST_SYNC:   if (v_cnt_q == V_SYNC_LAST) v_state_d = ST_BP;
        ST_BP:     if (v_wrap)                 v_state_d = ST_ACTIVE;
      endcase
    end

    h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = v_wrap ? 12'd0 : v_cnt_q + 12'd1;

    // Disabled: park at the origin so the next enabled edge shows (0,0).
    if (!i_enable) begin
      h_cnt_d   = '0;
      v_cnt_d   = '0;
      h_state_d = ST_ACTIVE;
      v_state_d = ST_ACTIVE;
    end
  end

  // Output decode for the position currently held in the counters.
  always_comb begin
    de_d          = (h_state_q == ST_ACTIVE) && (v_state_q == ST_ACTIVE);
    hsync_on_d    = (h_state_q == ST_SYNC);
    vsync_on_d    = (v_state_q == ST_SYNC);
    guard_d       = HDMI_EN && next_line_active && (h_cnt_q >= H_GUARD_FIRST);
    ctl_d         = '0;
    if (HDMI_EN && next_line_active &&
        (h_cnt_q >= H_PRE_FIRST) && (h_cnt_q <= H_PRE_LAST))
      ctl_d = 4'b0001;  // video data period preamble
    x_d           = h_cnt_q;
    y_d           = v_cnt_q;
    line_start_d  = (h_cnt_q == 12'd0);
    frame_start_d = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    if (!i_enable) begin
      de_d          = 1'b0;
      hsync_on_d    = 1'b0;
      vsync_on_d    = 1'b0;
      guard_d       = 1'b0;
      ctl_d         = '0;
      x_d           = '0;
      y_d           = '0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  // Gating with i_enable makes a mid-line disable take effect immediately
  // instead of at the next edge.
  assign o_de          = de_q & i_enable;
  assign o_guard       = guard_q & i_enable;
  assign o_hsync       = (hsync_on_q & i_enable) ? HS_ON : ~HS_ON;
  assign o_vsync       = (vsync_on_q & i_enable) ? VS_ON : ~VS_ON;
  assign o_ctrl_ch0    = {o_vsync, o_hsync};
  assign o_ctrl_ch1    = i_enable ? ctl_q[1:0] : 2'b00;
  assign o_ctrl_ch2    = i_enable ? ctl_q[3:2] : 2'b00;
  assign o_x           = i_enable ? x_q : 12'd0;
  assign o_y           = i_enable ? y_q : 12'd0;
  assign o_line_start  = line_start_q & i_enable;
  assign o_frame_start = frame_start_q & i_enable;

endmodule
